// File: rtl/efuse_shadow_load.sv
// ---------------------------------------------------------------------------
// efuse_shadow_load
//   Requests an efuse load after power-up release and captures the image that
//   the efuse controller reports. The image is validated with an XOR checksum:
//   the XOR of bytes 0..N-2 must equal byte N-1. Failed attempts are retried.
//   The result is published as a shadow trim vector. DEFAULT_TRIM is
//   substituted when the image is blank or when every attempt fails.
//
// Optional feature (macro EFUSE_SHADOW_LOCK_EN):
//   Adds o_efuse_locked, which is the MSB of shadow byte 0 for a valid,
//   non-blank and non-failed load. While it is set, i_reload_p is ignored.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               level, power-up release (sampled in IDLE)
//   i_reload_p            single-cycle software reload (honoured in DONE/FAIL)
//   o_efuse_load_req      single-cycle load request to the efuse controller
//   i_efuse_load_done     controller finished the load
//   i_efuse_reg_update    i_efuse_reg_data valid this cycle
//   i_efuse_reg_data      image from the controller
//   o_trim_data           shadow image
//   o_trim_vld            shadow image is final
//   o_load_busy           load sequence in progress
//   o_load_fail           all attempts failed, defaults applied
//   o_chk_err / o_tmo_err error kind of the last failed attempt
//   o_blank               image was all-zero, defaults applied
//   o_retry_cnt           retries used (saturating)
// ---------------------------------------------------------------------------
module efuse_shadow_load #(
    parameter int unsigned EFUSE_DATA_NUM = 8,
    parameter int unsigned EFUSE_DW       = 8,
    parameter int unsigned TMO_CYC_NUM    = 4096,
    parameter int unsigned RETRY_NUM      = 3,
    parameter logic [EFUSE_DATA_NUM*EFUSE_DW-1:0] DEFAULT_TRIM = {(EFUSE_DATA_NUM*EFUSE_DW){1'b0}}
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start,
    input  logic                               i_reload_p,
    output logic                               o_efuse_load_req,
    input  logic                               i_efuse_load_done,
    input  logic                               i_efuse_reg_update,
    input  logic [EFUSE_DATA_NUM*EFUSE_DW-1:0] i_efuse_reg_data,
    output logic [EFUSE_DATA_NUM*EFUSE_DW-1:0] o_trim_data,
    output logic                               o_trim_vld,
    output logic                               o_load_busy,
    output logic                               o_load_fail,
    output logic                               o_chk_err,
    output logic                               o_tmo_err,
    output logic                               o_blank,
    output logic [1:0]                         o_retry_cnt
`ifdef EFUSE_SHADOW_LOCK_EN
    ,
    output logic                               o_efuse_locked
`endif
);

    localparam int unsigned IMG_W = EFUSE_DATA_NUM * EFUSE_DW;
    localparam int unsigned TMO_W = (TMO_CYC_NUM > 2) ? $clog2(TMO_CYC_NUM) : 1;
    localparam int unsigned RTY_W = ($clog2(RETRY_NUM + 1) > 2) ? $clog2(RETRY_NUM + 1) : 2;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC_NUM - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(RETRY_NUM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    // XOR of every data byte must equal the final checksum byte.
    function automatic logic csum_ok(input logic [IMG_W-1:0] img);
        logic [EFUSE_DW-1:0] acc;
        acc = {EFUSE_DW{1'b0}};
        for (int unsigned i = 0; i < EFUSE_DATA_NUM - 1; i++) begin
            acc = acc ^ img[i*EFUSE_DW +: EFUSE_DW];
        end
        return acc == img[(EFUSE_DATA_NUM-1)*EFUSE_DW +: EFUSE_DW];
    endfunction

    state_t             state_r, state_nxt_s;
    logic [IMG_W-1:0]   cap_r;
    logic               got_data_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [RTY_W-1:0]   retry_r, retry_d_s;
    logic               load_start_s, ok_s, blank_s, err_s, err_chk_s, exhaust_s;
    logic               locked_s;
    logic [IMG_W-1:0]   trim_d_s;
    logic               vld_d_s, busy_d_s, req_d_s, fail_d_s, chk_d_s, tmo_d_s, blank_d_s;
    logic [1:0]         retry_disp_d_s;

`ifdef EFUSE_SHADOW_LOCK_EN
    logic               locked_d_s;
    assign locked_s = o_efuse_locked;
`else
    assign locked_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-cycle load events.
    always_comb begin
        state_nxt_s  = state_r;
        load_start_s = 1'b0;
        ok_s         = 1'b0;
        blank_s      = 1'b0;
        err_s        = 1'b0;
        err_chk_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt_s  = S_REQ;
                    load_start_s = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                state_nxt_s = S_WAIT;
            end
            S_WAIT: begin
                // done wins over a timeout landing in the same cycle
                if (i_efuse_load_done) begin
                    state_nxt_s = S_CHECK;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    err_s = 1'b1;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_CHECK: begin
                if (!got_data_r) begin
                    err_s = 1'b1;
                end else if (cap_r == {IMG_W{1'b0}}) begin
                    ok_s    = 1'b1;
                    blank_s = 1'b1;
                end else if (csum_ok(cap_r)) begin
                    ok_s = 1'b1;
                end else begin
                    err_s     = 1'b1;
                    err_chk_s = 1'b1;
                end
            end
            S_DONE, S_FAIL: begin
                if (i_reload_p && !locked_s) begin
                    state_nxt_s  = S_REQ;
                    load_start_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        exhaust_s = err_s && (retry_r >= RTY_MAX);
        if (ok_s) begin
            state_nxt_s = S_DONE;
        end else if (err_s) begin
            state_nxt_s = exhaust_s ? S_FAIL : S_REQ;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Next values of the published outputs and the retry counter.
    always_comb begin
        trim_d_s  = o_trim_data;
        fail_d_s  = o_load_fail;
        chk_d_s   = o_chk_err;
        tmo_d_s   = o_tmo_err;
        blank_d_s = o_blank;
        retry_d_s = retry_r;
        if (load_start_s) begin
            fail_d_s  = 1'b0;
            chk_d_s   = 1'b0;
            tmo_d_s   = 1'b0;
            blank_d_s = 1'b0;
            retry_d_s = {RTY_W{1'b0}};
        end else if (ok_s) begin
            trim_d_s  = blank_s ? DEFAULT_TRIM : cap_r;
            blank_d_s = blank_s;
            chk_d_s   = 1'b0;
            tmo_d_s   = 1'b0;
        end else if (err_s) begin
            chk_d_s = err_chk_s;
            tmo_d_s = !err_chk_s;
            if (exhaust_s) begin
                trim_d_s = DEFAULT_TRIM;
                fail_d_s = 1'b1;
            end else begin
                retry_d_s = retry_r + RTY_W'(1);
            end
        end else begin
            trim_d_s = o_trim_data;
        end
        retry_disp_d_s = (retry_d_s > RTY_W'(3)) ? 2'd3 : retry_d_s[1:0];
        req_d_s  = (state_nxt_s == S_REQ);
        busy_d_s = (state_nxt_s == S_REQ) || (state_nxt_s == S_WAIT) || (state_nxt_s == S_CHECK);
        vld_d_s  = (state_nxt_s == S_DONE) || (state_nxt_s == S_FAIL);
`ifdef EFUSE_SHADOW_LOCK_EN
        locked_d_s = vld_d_s && !blank_d_s && !fail_d_s && trim_d_s[EFUSE_DW-1];
`endif
    end

    // Capture buffer and per-attempt timeout counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cap_r      <= {IMG_W{1'b0}};
            got_data_r <= 1'b0;
            tmo_cnt_r  <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                S_REQ: begin
                    got_data_r <= 1'b0;
                    tmo_cnt_r  <= {TMO_W{1'b0}};
                end
                S_WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    if (i_efuse_reg_update) begin
                        cap_r      <= i_efuse_reg_data;
                        got_data_r <= 1'b1;
                    end else begin
                        got_data_r <= got_data_r;
                    end
                end
                default: begin
                    tmo_cnt_r <= tmo_cnt_r;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_trim_data      <= DEFAULT_TRIM;
            o_trim_vld       <= 1'b0;
            o_load_busy      <= 1'b0;
            o_efuse_load_req <= 1'b0;
            o_load_fail      <= 1'b0;
            o_chk_err        <= 1'b0;
            o_tmo_err        <= 1'b0;
            o_blank          <= 1'b0;
            o_retry_cnt      <= 2'd0;
            retry_r          <= {RTY_W{1'b0}};
`ifdef EFUSE_SHADOW_LOCK_EN
            o_efuse_locked   <= 1'b0;
`endif
        end else begin
            o_trim_data      <= trim_d_s;
            o_trim_vld       <= vld_d_s;
            o_load_busy      <= busy_d_s;
            o_efuse_load_req <= req_d_s;
            o_load_fail      <= fail_d_s;
            o_chk_err        <= chk_d_s;
            o_tmo_err        <= tmo_d_s;
            o_blank          <= blank_d_s;
            o_retry_cnt      <= retry_disp_d_s;
            retry_r          <= retry_d_s;
`ifdef EFUSE_SHADOW_LOCK_EN
            o_efuse_locked   <= locked_d_s;
`endif
        end
    end

endmodule

// File: tb/tb_efuse_shadow_load.sv
module tb_efuse_shadow_load;

    localparam int unsigned N   = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 256;
    localparam int unsigned RTY = 3;
    localparam logic [63:0] DEF = 64'h0123_4567_89AB_CDEF;

    // attempt kinds
    localparam int K_TMO  = 0;  // no response at all
    localparam int K_IMG  = 1;  // update + done
    localparam int K_DONE = 2;  // done without data

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_reload_p = 1'b0;
    logic        i_efuse_load_done = 1'b0, i_efuse_reg_update = 1'b0;
    logic [63:0] i_efuse_reg_data = 64'd0;
    logic        o_efuse_load_req, o_trim_vld, o_load_busy, o_load_fail;
    logic        o_chk_err, o_tmo_err, o_blank;
    logic [63:0] o_trim_data;
    logic [1:0]  o_retry_cnt;
`ifdef EFUSE_SHADOW_LOCK_EN
    logic        o_efuse_locked;
`endif

    efuse_shadow_load #(
        .EFUSE_DATA_NUM(N), .EFUSE_DW(DW), .TMO_CYC_NUM(TMO),
        .RETRY_NUM(RTY), .DEFAULT_TRIM(DEF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_reload_p(i_reload_p),
        .o_efuse_load_req(o_efuse_load_req), .i_efuse_load_done(i_efuse_load_done),
        .i_efuse_reg_update(i_efuse_reg_update), .i_efuse_reg_data(i_efuse_reg_data),
        .o_trim_data(o_trim_data), .o_trim_vld(o_trim_vld), .o_load_busy(o_load_busy),
        .o_load_fail(o_load_fail), .o_chk_err(o_chk_err), .o_tmo_err(o_tmo_err),
        .o_blank(o_blank), .o_retry_cnt(o_retry_cnt)
`ifdef EFUSE_SHADOW_LOCK_EN
        , .o_efuse_locked(o_efuse_locked)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] trim;
        bit          blank, fail, chk, tmo, from_check;
        int unsigned retry, nreq;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0, miscompares = 0;
    int unsigned done_cyc = 0, req_seen = 0;
    logic [63:0] held_trim = DEF;
    int          att_kind[4];
    logic [63:0] att_img[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit xor_ok(input logic [63:0] v);
        logic [7:0] acc = 8'd0;
        for (int i = 0; i < 7; i++) acc = acc ^ v[i*8 +: 8];
        return acc == v[63:56];
    endfunction

    // Reference: walk the attempts in order, applying the load rules directly.
    function automatic exp_t model();
        exp_t e;
        e.trim = DEF; e.blank = 0; e.fail = 0; e.chk = 0; e.tmo = 0;
        e.retry = 0; e.nreq = 0; e.from_check = 0;
        for (int a = 0; a < 4; a++) begin
            e.nreq = a + 1;
            e.from_check = (att_kind[a] != K_TMO);
            if (att_kind[a] == K_IMG && att_img[a] == 64'd0) begin
                e.trim = DEF; e.blank = 1; e.chk = 0; e.tmo = 0;
                return e;
            end
            if (att_kind[a] == K_IMG && xor_ok(att_img[a])) begin
                e.trim = att_img[a]; e.chk = 0; e.tmo = 0;
                return e;
            end
            e.chk = (att_kind[a] == K_IMG);
            e.tmo = !e.chk;
            if (a == RTY) begin
                e.fail = 1; e.trim = DEF;
                return e;
            end
            e.retry = a + 1;
        end
        return e;
    endfunction

    // Monitor: compares the published result whenever o_trim_vld rises.
    initial begin : monitor
        exp_t e;
        bit   prev_vld = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 0;
            end else begin
                if (o_efuse_load_req) begin
                    req_seen++;
                    check("busy_at_req", 64'(o_load_busy), 64'd1);
                    check("trim_held", o_trim_data, held_trim);
                end
                if (o_trim_vld && !prev_vld) begin
                    if (sb_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_vld: got vld=1 expected no result");
                    end else begin
                        e = sb_q.pop_front();
                        check("trim_data", o_trim_data, e.trim);
                        check("blank", 64'(o_blank), 64'(e.blank));
                        check("load_fail", 64'(o_load_fail), 64'(e.fail));
                        check("chk_err", 64'(o_chk_err), 64'(e.chk));
                        check("tmo_err", 64'(o_tmo_err), 64'(e.tmo));
                        check("retry_cnt", 64'(o_retry_cnt), 64'(e.retry > 3 ? 3 : e.retry));
                        check("load_req_count", 64'(req_seen), 64'(e.nreq));
                        check("busy_in_done", 64'(o_load_busy), 64'd0);
                        if (e.from_check)
                            check("done_to_vld_latency", 64'(cyc - done_cyc), 64'd2);
`ifdef EFUSE_SHADOW_LOCK_EN
                        check("locked", 64'(o_efuse_locked),
                              64'(!e.blank && !e.fail && e.trim[DW-1]));
`endif
                        held_trim = e.trim;
                        req_seen  = 0;
                    end
                end
                prev_vld = o_trim_vld;
            end
        end
    end

    // Looks at the current negedge first, then advances up to a bound.
    task automatic wait_req(output int unsigned c, output bit ok);
        ok = 0; c = 0;
        for (int i = 0; i < 2 * TMO + 20; i++) begin
            if (o_efuse_load_req) begin
                c = cyc; ok = 1;
                return;
            end
            @(negedge clk);
        end
        vectors++; miscompares++;
        $display("FAIL wait_load_req: got no request expected one within %0d cycles", 2 * TMO + 20);
    endtask

    task automatic wait_vld();
        for (int i = 0; i < 2 * TMO + 20; i++) begin
            if (o_trim_vld) return;
            @(negedge clk);
        end
        vectors++; miscompares++;
        $display("FAIL wait_trim_vld: got vld=0 expected vld=1 within bound");
    endtask

    // Runs one full load using att_kind/att_img; the model result goes to the scoreboard.
    task automatic run_load(input bit use_start);
        exp_t        e;
        int unsigned c, prev_c;
        bit          ok;
        e = model();
        sb_q.push_back(e);
        @(negedge clk);
        if (use_start) i_start = 1'b1; else i_reload_p = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_reload_p = 1'b0;
        if (!use_start) begin
            check("vld_drop_after_reload", 64'(o_trim_vld), 64'd0);
            check("data_held_after_reload", o_trim_data, held_trim);
        end
        prev_c = 0;
        for (int a = 0; a < int'(e.nreq); a++) begin
            wait_req(c, ok);
            if (!ok) return;
            if (a > 0 && att_kind[a-1] == K_TMO)
                check("tmo_req_spacing", 64'(c - prev_c), 64'(TMO + 1));
            prev_c = c;
            if (att_kind[a] == K_TMO) begin
                @(negedge clk);
            end else begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                if (att_kind[a] == K_IMG) begin
                    if ($urandom_range(0, 2) == 0) begin
                        i_efuse_reg_data = {$urandom, $urandom};
                        i_efuse_reg_update = 1'b1;
                        @(negedge clk);
                        i_efuse_reg_update = 1'b0;
                    end
                    i_efuse_reg_data = att_img[a];
                    i_efuse_reg_update = 1'b1;
                    if ($urandom_range(0, 1) == 0) begin
                        @(negedge clk);
                        i_efuse_reg_update = 1'b0;
                    end
                end
                i_efuse_load_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                i_efuse_load_done = 1'b0;
                i_efuse_reg_update = 1'b0;
            end
        end
        wait_vld();
        @(negedge clk);
    endtask

    function automatic logic [63:0] good_img();
        logic [63:0] v;
        logic [7:0]  acc = 8'd0;
        v = {$urandom, $urandom};
`ifdef EFUSE_SHADOW_LOCK_EN
        v[DW-1] = 1'b0;
`endif
        for (int i = 0; i < 7; i++) acc = acc ^ v[i*8 +: 8];
        v[63:56] = acc;
        return v;
    endfunction

    task automatic set_att(input int k0, input logic [63:0] v0, input int k1, input logic [63:0] v1,
                           input int k2, input logic [63:0] v2, input int k3, input logic [63:0] v3);
        att_kind[0] = k0; att_img[0] = v0; att_kind[1] = k1; att_img[1] = v1;
        att_kind[2] = k2; att_img[2] = v2; att_kind[3] = k3; att_img[3] = v3;
    endtask

    initial begin : watchdog
        #(10 * 90000);
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [63:0] gimg, bimg, v;
        int r;
        gimg = 64'h7F40_2010_0804_0201;
        bimg = 64'h0040_2010_0804_0201;
        repeat (3) @(negedge clk);
        check("rst_trim", o_trim_data, DEF);
        check("rst_flags", 64'({o_trim_vld, o_load_busy, o_efuse_load_req, o_load_fail,
                                o_chk_err, o_tmo_err, o_blank, o_retry_cnt}), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_req", 64'(o_efuse_load_req), 64'd0);

        set_att(K_IMG, gimg, K_IMG, gimg, K_IMG, gimg, K_IMG, gimg);
        run_load(1'b1);
        set_att(K_IMG, 64'd0, K_IMG, gimg, K_IMG, gimg, K_IMG, gimg);
        run_load(1'b0);
        set_att(K_IMG, bimg, K_IMG, gimg, K_IMG, gimg, K_IMG, gimg);
        run_load(1'b0);
        set_att(K_TMO, 64'd0, K_TMO, 64'd0, K_TMO, 64'd0, K_TMO, 64'd0);
        run_load(1'b0);

        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 4; a++) begin
                r = int'($urandom_range(0, 9));
                v = good_img();
                if (r == 0) begin att_kind[a] = K_TMO; att_img[a] = 64'd0; end
                else if (r == 1) begin att_kind[a] = K_DONE; att_img[a] = 64'd0; end
                else if (r == 2) begin att_kind[a] = K_IMG; att_img[a] = 64'd0; end
                else if (r < 6) begin
                    att_kind[a] = K_IMG;
                    v[63:56] = v[63:56] ^ 8'($urandom_range(1, 255));
                    att_img[a] = v;
                end else begin att_kind[a] = K_IMG; att_img[a] = v; end
            end
            run_load(1'b0);
        end

        // asynchronous reset while waiting for the controller
        begin
            int unsigned c;
            bit ok;
            @(negedge clk);
            i_reload_p = 1'b1;
            @(negedge clk);
            i_reload_p = 1'b0;
            wait_req(c, ok);
            repeat (3) @(negedge clk);
            check("busy_in_wait", 64'(o_load_busy), 64'd1);
            #2 rst = 1'b1;
            #1;
            check("async_rst_trim", o_trim_data, DEF);
            check("async_rst_flags", 64'({o_trim_vld, o_load_busy, o_efuse_load_req, o_load_fail,
                                          o_chk_err, o_tmo_err, o_blank, o_retry_cnt}), 64'd0);
            held_trim = DEF;
            req_seen = 0;
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
        end

        // restart after reset; byte 0 has its MSB set
        v = 64'h0000_0000_0000_0080;
        v[63:56] = 8'h80;
        set_att(K_IMG, v, K_IMG, v, K_IMG, v, K_IMG, v);
        run_load(1'b1);
`ifdef EFUSE_SHADOW_LOCK_EN
        check("locked_set", 64'(o_efuse_locked), 64'd1);
        @(negedge clk);
        i_reload_p = 1'b1;
        @(negedge clk);
        i_reload_p = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("locked_no_req", 64'(o_efuse_load_req), 64'd0);
            check("locked_vld_kept", 64'(o_trim_vld), 64'd1);
            @(negedge clk);
        end
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
